// File: rtl/qspi_pkg.sv
// rtl/qspi_pkg.sv - shared QSPI Fast Read Quad I/O constants and state type
package qspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_MODE,
        ST_DUMMY,
        ST_DATA,
        ST_DESEL
    } qspi_state_e;

    localparam logic [7:0] CMD_FAST_READ_QUAD_IO = 8'hEB;
    localparam logic [7:0] MODE_BYTE             = 8'h00;

    localparam logic [4:0] CMD_SLOTS   = 5'd8;
    localparam logic [4:0] ADDR_SLOTS  = 5'd6;
    localparam logic [4:0] MODE_SLOTS  = 5'd2;
    localparam logic [4:0] DUMMY_SLOTS = 5'd4;
    localparam logic [4:0] DATA_SLOTS  = 5'd2;

    function automatic logic [4:0] last_slot(input qspi_state_e s);
        case (s)
            ST_CMD:   last_slot = CMD_SLOTS - 5'd1;
            ST_ADDR:  last_slot = ADDR_SLOTS - 5'd1;
            ST_MODE:  last_slot = MODE_SLOTS - 5'd1;
            ST_DUMMY: last_slot = DUMMY_SLOTS - 5'd1;
            ST_DATA:  last_slot = DATA_SLOTS - 5'd1;
            default:  last_slot = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/qspi_rom_reader.sv
// rtl/qspi_rom_reader.sv - one-byte 0xEB quad read per ROM request, all outputs registered
module qspi_rom_reader
    import qspi_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter logic [23:0] BASE_ADDR = 24'h100000,
    parameter int unsigned CS_HIGH   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [7:0]        rsp_data,
    output logic              spi_select,
    output logic              spi_sclk,
    output logic [3:0]        spi_io_out,
    output logic [3:0]        spi_io_oe,
    input  logic [3:0]        spi_io_in
);

    qspi_state_e state_q, state_d;
    logic [4:0]  slot_q, slot_d;
    logic        phase_q, phase_d;
    logic [23:0] sr_q, sr_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        select_q, select_d;
    logic        sclk_q, sclk_d;
    logic [3:0]  io_out_q, io_out_d;
    logic [3:0]  io_oe_q, io_oe_d;

    logic        slot_last;
    logic [2:0]  cmd_idx;
    logic [7:0]  cmd_byte;

    assign slot_last = (slot_q == last_slot(state_q));
    assign cmd_idx   = 3'd6 - slot_q[2:0];
    assign cmd_byte  = CMD_FAST_READ_QUAD_IO;

    // Every _d is the value for the cycle after this edge, so io changes land with sclk low
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        phase_d     = phase_q;
        sr_d        = sr_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        select_d    = select_q;
        sclk_d      = sclk_q;
        io_out_d    = io_out_q;
        io_oe_d     = io_oe_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d     = ST_CMD;
                    slot_d      = 5'd0;
                    phase_d     = 1'b0;
                    sr_d        = BASE_ADDR + 24'(req_addr);
                    req_ready_d = 1'b0;
                    select_d    = 1'b0;
                    sclk_d      = 1'b0;
                    io_out_d    = {3'b000, cmd_byte[7]};
                    io_oe_d     = 4'b0001;
                end
            end
            ST_DESEL: begin
                if ({27'd0, slot_q} + 32'd1 >= CS_HIGH) begin
                    state_d     = ST_IDLE;
                    slot_d      = 5'd0;
                    req_ready_d = 1'b1;
                end else begin
                    slot_d = slot_q + 5'd1;
                end
            end
            default: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    sclk_d  = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    sclk_d  = 1'b0;
                    slot_d  = slot_last ? 5'd0 : slot_q + 5'd1;
                    case (state_q)
                        ST_CMD: begin
                            if (!slot_last) begin
                                io_out_d = {3'b000, cmd_byte[cmd_idx]};
                            end else begin
                                state_d  = ST_ADDR;
                                io_out_d = sr_q[23:20];
                                io_oe_d  = 4'b1111;
                            end
                        end
                        ST_ADDR: begin
                            sr_d = {sr_q[19:0], 4'h0};
                            if (!slot_last) begin
                                io_out_d = sr_q[19:16];
                            end else begin
                                state_d  = ST_MODE;
                                io_out_d = MODE_BYTE[7:4];
                            end
                        end
                        ST_MODE: begin
                            if (!slot_last) begin
                                io_out_d = MODE_BYTE[3:0];
                            end else begin
                                state_d  = ST_DUMMY;
                                io_out_d = 4'h0;
                                io_oe_d  = 4'b0000;
                            end
                        end
                        ST_DUMMY: begin
                            if (slot_last) begin
                                state_d = ST_DATA;
                            end
                        end
                        ST_DATA: begin
                            // The address has fully shifted out, so the low nibble is free for the read data
                            sr_d = {sr_q[19:0], spi_io_in};
                            if (slot_last) begin
                                state_d     = ST_DESEL;
                                rsp_valid_d = 1'b1;
                                rsp_data_d  = {sr_q[3:0], spi_io_in};
                                select_d    = 1'b1;
                                io_out_d    = 4'h0;
                                io_oe_d     = 4'b0000;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            slot_q      <= 5'd0;
            phase_q     <= 1'b0;
            sr_q        <= 24'h0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            select_q    <= 1'b1;
            sclk_q      <= 1'b0;
            io_out_q    <= 4'h0;
            io_oe_q     <= 4'h0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            phase_q     <= phase_d;
            sr_q        <= sr_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            select_q    <= select_d;
            sclk_q      <= sclk_d;
            io_out_q    <= io_out_d;
            io_oe_q     <= io_oe_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign spi_select = select_q;
    assign spi_sclk   = sclk_q;
    assign spi_io_out = io_out_q;
    assign spi_io_oe  = io_oe_q;

endmodule

// File: tb/tb_qspi_rom_reader.sv
// tb/tb_qspi_rom_reader.sv - self-checking bench for qspi_rom_reader
module tb_qspi_rom_reader;

    localparam int          CS_HIGH = 2;
    localparam logic [23:0] BASE    = 24'h100000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid;
    logic [11:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        spi_select;
    logic        spi_sclk;
    logic [3:0]  spi_io_out;
    logic [3:0]  spi_io_oe;
    logic [3:0]  spi_io_in;

    logic        w_req_valid;
    logic [11:0] w_req_addr;
    logic        w_req_ready;
    logic        w_rsp_valid;
    logic [7:0]  w_rsp_data;
    logic        w_spi_select;
    logic        w_spi_sclk;
    logic [3:0]  w_spi_io_out;
    logic [3:0]  w_spi_io_oe;
    logic [3:0]  w_spi_io_in;

    qspi_rom_reader #(.ADDR_W(12), .BASE_ADDR(BASE), .CS_HIGH(CS_HIGH)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .spi_select(spi_select), .spi_sclk(spi_sclk), .spi_io_out(spi_io_out),
        .spi_io_oe(spi_io_oe), .spi_io_in(spi_io_in)
    );

    qspi_rom_reader #(.ADDR_W(12), .BASE_ADDR(24'hFFFFF0), .CS_HIGH(CS_HIGH)) u_wrap (
        .clk(clk), .rst_n(rst_n), .req_valid(w_req_valid), .req_addr(w_req_addr),
        .req_ready(w_req_ready), .rsp_valid(w_rsp_valid), .rsp_data(w_rsp_data),
        .spi_select(w_spi_select), .spi_sclk(w_spi_sclk), .spi_io_out(w_spi_io_out),
        .spi_io_oe(w_spi_io_oe), .spi_io_in(w_spi_io_in)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    bit          txn_active = 1'b0;
    int          acc_cyc = 0;
    int          last_rsp_cyc = -1000;
    int          rsp_cnt = 0;
    int          rises = 0;
    logic [23:0] exp_addr = 24'h0;
    logic [7:0]  flash_byte = 8'h00;
    logic [7:0]  pending_byte = 8'h00;
    logic [7:0]  rec[$];
    logic        prev_sclk = 1'b0;
    logic [3:0]  w_rec[$];
    logic        w_prev_sclk = 1'b0;
    int          w_rsp_cnt = 0;
    logic [7:0]  w_last = 8'h00;

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected {io_out, oe} at the k-th rising sclk of a transaction reading flash address a
    function automatic logic [7:0] exp_edge(input int k, input logic [23:0] a);
        logic [7:0] cmd;
        cmd = 8'hEB;
        if (k < 8)       return {3'b000, cmd[7-k], 4'b0001};
        else if (k < 14) return {a[4*(13-k) +: 4], 4'b1111};
        else if (k < 16) return 8'h0F;
        else             return 8'h00;
    endfunction

    task automatic tick();
        bit          pre_acc;
        logic [11:0] pa;
        pre_acc = rst_n && req_valid && req_ready;
        pa      = req_addr;
        @(posedge clk);
        cyc++;
        #1;
        if (!rst_n) begin
            txn_active  = 1'b0;
            prev_sclk   = spi_sclk;
            w_prev_sclk = w_spi_sclk;
            return;
        end
        if (pre_acc) begin
            chk_eq("double_accept", 32'(txn_active), 32'd0);
            chk_eq("accept_spacing", 32'((cyc - last_rsp_cyc) >= CS_HIGH + 1), 32'd1);
            txn_active = 1'b1;
            acc_cyc    = cyc;
            exp_addr   = BASE + {12'h000, pa};
            flash_byte = pending_byte;
            rises      = 0;
            rec.delete();
            chk_eq("e0_select", 32'(spi_select), 32'd0);
            chk_eq("e0_ready", 32'(req_ready), 32'd0);
            chk_eq("e0_sclk", 32'(spi_sclk), 32'd0);
        end else if (txn_active) begin
            chk_eq("busy_ready", 32'(req_ready), 32'd0);
        end
        if (txn_active && spi_sclk && !prev_sclk) begin
            rises++;
            rec.push_back({spi_io_out, spi_io_oe});
            if (rises == 21)      spi_io_in = flash_byte[7:4];
            else if (rises == 22) spi_io_in = flash_byte[3:0];
            else                  spi_io_in = 4'($urandom);
        end else if (!txn_active) begin
            spi_io_in = 4'($urandom);
        end
        if (rsp_valid) begin
            chk_eq("rsp_expected", 32'(txn_active), 32'd1);
            if (txn_active) begin
                chk_eq("latency", 32'(cyc - acc_cyc), 32'd44);
                chk_eq("rsp_data", 32'(rsp_data), 32'(flash_byte));
                chk_eq("sclk_rises", 32'(rises), 32'd22);
                for (int k = 0; k < rec.size(); k++)
                    chk_eq($sformatf("edge%0d", k), 32'(rec[k]), 32'(exp_edge(k, exp_addr)));
                chk_eq("e44_select", 32'(spi_select), 32'd1);
                chk_eq("e44_oe", 32'(spi_io_oe), 32'd0);
                chk_eq("e44_sclk", 32'(spi_sclk), 32'd0);
                txn_active   = 1'b0;
                last_rsp_cyc = cyc;
                rsp_cnt++;
            end
        end
        if (w_spi_sclk && !w_prev_sclk && !w_spi_select) w_rec.push_back(w_spi_io_out);
        if (w_rsp_valid) begin
            w_rsp_cnt++;
            w_last = w_rsp_data;
        end
        prev_sclk   = spi_sclk;
        w_prev_sclk = w_spi_sclk;
    endtask

    task automatic run_read(input logic [11:0] a, input logic [7:0] d, input bit noisy);
        int guard;
        pending_byte = d;
        req_addr     = a;
        req_valid    = 1'b1;
        guard = 0;
        while (!txn_active && guard < 200) begin
            tick();
            guard++;
        end
        req_valid = 1'b0;
        if (!txn_active) begin
            chk_eq("accept_timeout", 32'd0, 32'd1);
            return;
        end
        guard = 0;
        while (txn_active && guard < 200) begin
            if (noisy) begin
                req_valid = 1'($urandom);
                req_addr  = 12'($urandom);
            end
            tick();
            guard++;
        end
        req_valid = 1'b0;
        if (txn_active) chk_eq("rsp_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
        logic [23:0] fa;
    } vec_t;

    initial begin
        vec_t vt[5];
        int   acc1, hi, rcnt, guard;

        vt[0] = '{12'h123, 8'hA5, 24'h100123};
        vt[1] = '{12'h000, 8'h3C, 24'h100000};
        vt[2] = '{12'hFFF, 8'h5A, 24'h100FFF};
        vt[3] = '{12'h800, 8'hFF, 24'h100800};
        vt[4] = '{12'h0F0, 8'h00, 24'h1000F0};

        rst_n = 1'b0; req_valid = 1'b0; req_addr = 12'h0; spi_io_in = 4'h0;
        w_req_valid = 1'b0; w_req_addr = 12'h0; w_spi_io_in = 4'h7;

        for (int i = 0; i < 5; i++) begin
            req_valid = 1'($urandom);
            req_addr  = 12'($urandom);
            tick();
            chk_eq("rst_ready", 32'(req_ready), 32'd1);
            chk_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
            chk_eq("rst_select", 32'(spi_select), 32'd1);
            chk_eq("rst_sclk", 32'(spi_sclk), 32'd0);
            chk_eq("rst_io_out", 32'(spi_io_out), 32'd0);
            chk_eq("rst_oe", 32'(spi_io_oe), 32'd0);
        end
        req_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk_eq("release_ready", 32'(req_ready), 32'd1);
        chk_eq("release_select", 32'(spi_select), 32'd1);

        for (int i = 0; i < 5; i++) begin
            run_read(vt[i].addr, vt[i].data, 1'b0);
            chk_eq("vec_data", 32'(rsp_data), 32'(vt[i].data));
            if (rec.size() == 22)
                chk_eq("vec_addr", 32'({rec[8][7:4], rec[9][7:4], rec[10][7:4],
                                        rec[11][7:4], rec[12][7:4], rec[13][7:4]}), 32'(vt[i].fa));
            else
                chk_eq("vec_rec_size", 32'(rec.size()), 32'd22);
            repeat (3) tick();
        end

        // Back-to-back with req_valid held high
        pending_byte = 8'h11; req_addr = 12'h000; req_valid = 1'b1;
        guard = 0;
        while (!txn_active && guard < 50) begin tick(); guard++; end
        acc1 = acc_cyc;
        pending_byte = 8'h22; req_addr = 12'h001;
        guard = 0;
        while (txn_active && guard < 100) begin tick(); guard++; end
        hi = 0; guard = 0;
        while (!txn_active && guard < 50) begin
            hi += int'(spi_select);
            tick();
            guard++;
        end
        chk_eq("b2b_spacing", 32'(acc_cyc - acc1), 32'(45 + CS_HIGH));
        chk_eq("b2b_select_high", 32'(hi), 32'(CS_HIGH + 1));
        req_valid = 1'b0;
        guard = 0;
        while (txn_active && guard < 100) begin tick(); guard++; end
        chk_eq("b2b_second_data", 32'(rsp_data), 32'h22);
        repeat (4) tick();

        // Requests toggling while busy
        rcnt = rsp_cnt;
        run_read(12'h456, 8'hC3, 1'b1);
        repeat (10) tick();
        chk_eq("busy_one_rsp", 32'(rsp_cnt - rcnt), 32'd1);
        chk_eq("busy_no_extra_txn", 32'(txn_active), 32'd0);

        // Reset in the middle of a transaction
        pending_byte = 8'h99; req_addr = 12'h2AB; req_valid = 1'b1;
        guard = 0;
        while (!txn_active && guard < 50) begin tick(); guard++; end
        req_valid = 1'b0;
        guard = 0;
        while (cyc < acc_cyc + 20 && guard < 50) begin tick(); guard++; end
        rcnt = rsp_cnt;
        rst_n = 1'b0;
        #1;
        chk_eq("midrst_select", 32'(spi_select), 32'd1);
        chk_eq("midrst_oe", 32'(spi_io_oe), 32'd0);
        chk_eq("midrst_sclk", 32'(spi_sclk), 32'd0);
        chk_eq("midrst_ready", 32'(req_ready), 32'd1);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (50) tick();
        chk_eq("midrst_no_rsp", 32'(rsp_cnt - rcnt), 32'd0);
        run_read(12'h2AB, 8'h66, 1'b0);
        chk_eq("midrst_next_data", 32'(rsp_data), 32'h66);

        for (int i = 0; i < 30; i++) begin
            run_read(12'($urandom), 8'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) tick();
        end

        // Address wrap past 2^24
        w_rec.delete();
        w_rsp_cnt = 0;
        w_req_addr = 12'h020;
        w_req_valid = 1'b1;
        tick();
        w_req_valid = 1'b0;
        repeat (60) tick();
        chk_eq("wrap_rises", 32'(w_rec.size()), 32'd22);
        if (w_rec.size() >= 14)
            chk_eq("wrap_addr", 32'({w_rec[8], w_rec[9], w_rec[10], w_rec[11], w_rec[12], w_rec[13]}), 32'h000010);
        chk_eq("wrap_rsp_cnt", 32'(w_rsp_cnt), 32'd1);
        chk_eq("wrap_data", 32'(w_last), 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
